// File: rtl/alu_decode_stage_pkg.sv
// Shared ALU operation codes and MIPS opcode/funct constants.
// Used by the decode stage and by the downstream ALU.
package alu_decode_stage_pkg;

    typedef enum logic [3:0] {
        ALU_AND     = 4'd0,
        ALU_OR      = 4'd1,
        ALU_ADD     = 4'd2,
        ALU_EQ      = 4'd3,
        ALU_LE      = 4'd4,
        ALU_GE      = 4'd5,
        ALU_SUB     = 4'd6,
        ALU_GT      = 4'd7,
        ALU_MUL     = 4'd8,
        ALU_DIV     = 4'd9,
        ALU_NE      = 4'd10,
        ALU_NOR     = 4'd12,
        ALU_ILLEGAL = 4'd15
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_SLTI     = 6'h0A;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_SW       = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_MUL  = 6'h02;

endpackage

// File: rtl/alu_ctr_decode.sv
// Combinational opcode/funct decode into ALU control and
// operand-steering flags.
module alu_ctr_decode
    import alu_decode_stage_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output alu_op_e    ctr,
    output logic       swap,
    output logic       use_imm,
    output logic       sign_ext,
    output logic       illegal
);

    always_comb begin
        ctr      = ALU_ILLEGAL;
        swap     = 1'b0;
        use_imm  = 1'b0;
        sign_ext = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                unique case (funct)
                    FN_ADD, FN_ADDU: ctr = ALU_ADD;
                    FN_SUB, FN_SUBU: ctr = ALU_SUB;
                    FN_AND:          ctr = ALU_AND;
                    FN_OR:           ctr = ALU_OR;
                    FN_NOR:          ctr = ALU_NOR;
                    FN_DIV:          ctr = ALU_DIV;
                    // slt as rt > rs
                    FN_SLT: begin
                        ctr  = ALU_GT;
                        swap = 1'b1;
                    end
                    default:         ctr = ALU_ILLEGAL;
                endcase
            end
            OP_SPECIAL2: begin
                if (funct == FN_MUL) ctr = ALU_MUL;
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
                ctr      = ALU_ADD;
                use_imm  = 1'b1;
                sign_ext = 1'b1;
            end
            OP_SLTI: begin
                ctr      = ALU_GT;
                swap     = 1'b1;
                use_imm  = 1'b1;
                sign_ext = 1'b1;
            end
            OP_ANDI: begin
                ctr     = ALU_AND;
                use_imm = 1'b1;
            end
            OP_ORI: begin
                ctr     = ALU_OR;
                use_imm = 1'b1;
            end
            OP_BEQ:  ctr = ALU_SUB;
            OP_BNE:  ctr = ALU_EQ;
            default: ctr = ALU_ILLEGAL;
        endcase
        illegal = (ctr == ALU_ILLEGAL);
    end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode stage: registers ALU control and operands behind a
// valid/ready skid-free pipeline register with flush.
module alu_decode_stage
    import alu_decode_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [15:0]      imm16,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       ALU_ctr,
    output logic [WIDTH-1:0] data1,
    output logic [WIDTH-1:0] data2,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    alu_op_e          dec_ctr;
    logic             dec_swap;
    logic             dec_use_imm;
    logic             dec_sign_ext;
    logic             dec_illegal;
    logic [WIDTH-1:0] ext_imm;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] nxt_d1;
    logic [WIDTH-1:0] nxt_d2;
    logic             xfer;
    logic             load;

    alu_ctr_decode u_dec (
        .opcode   (opcode),
        .funct    (funct),
        .ctr      (dec_ctr),
        .swap     (dec_swap),
        .use_imm  (dec_use_imm),
        .sign_ext (dec_sign_ext),
        .illegal  (dec_illegal)
    );

    always_comb begin
        ext_imm = {{(WIDTH-16){dec_sign_ext & imm16[15]}}, imm16};
        op_b    = dec_use_imm ? ext_imm : rt_data;
        nxt_d1  = rs_data;
        nxt_d2  = op_b;
        if (dec_illegal) begin
            nxt_d1 = '0;
            nxt_d2 = '0;
        end else if (dec_swap) begin
            nxt_d1 = op_b;
            nxt_d2 = rs_data;
        end
    end

    assign in_ready = !out_valid || out_ready;
    assign xfer     = in_valid && in_ready;
    // a flushed transfer leaves the entry and counter untouched
    assign load     = xfer && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            ALU_ctr     <= '0;
            data1       <= '0;
            data2       <= '0;
            illegal     <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            if (flush)
                out_valid <= 1'b0;
            else if (xfer)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
            if (load) begin
                ALU_ctr <= dec_ctr;
                data1   <= nxt_d1;
                data2   <= nxt_d2;
                illegal <= dec_illegal;
                if (dec_illegal && illegal_cnt != '1)
                    illegal_cnt <= illegal_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: directed vectors with
// hand-computed expectations, checked by a separate monitor.
module tb_alu_decode_stage;

    typedef struct packed {
        logic [3:0]  ctr;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [31:0] rs;
        logic [31:0] rt;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  ALU_ctr;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    exp_t sb[$];
    exp_t me;
    vec_t tbl[$];
    int   total = 0;
    int   bad = 0;
    int   exp_cnt = 0;

    alu_decode_stage #(.WIDTH(32), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .funct       (funct),
        .imm16       (imm16),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALU_ctr     (ALU_ctr),
        .data1       (data1),
        .data2       (data2),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [5:0] op, input logic [5:0] fn,
        input logic [15:0] imm, input logic [31:0] rs,
        input logic [31:0] rt, input logic [3:0] ctr,
        input logic [31:0] d1, input logic [31:0] d2,
        input logic ill);
        vec_t v;
        v.op = op; v.fn = fn; v.imm = imm;
        v.rs = rs; v.rt = rt;
        v.e.ctr = ctr; v.e.d1 = d1; v.e.d2 = d2; v.e.ill = ill;
        return v;
    endfunction

    // monitor: every consumed entry is compared against the queue
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got ctr=%0h want none",
                         ALU_ctr);
            end else begin
                me = sb.pop_front();
                chk("sb_ctr", ALU_ctr, me.ctr);
                chk("sb_data1", data1, me.d1);
                chk("sb_data2", data2, me.d2);
                chk("sb_illegal", illegal, me.ill);
            end
        end
    end

    task automatic send(input vec_t v, input bit drop);
        bit r;
        bit done = 1'b0;
        opcode   = v.op;
        funct    = v.fn;
        imm16    = v.imm;
        rs_data  = v.rs;
        rt_data  = v.rt;
        flush    = drop;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            if (r) begin
                done = 1'b1;
                if (!drop) begin
                    sb.push_back(v.e);
                    if (v.e.ill && exp_cnt < 255) exp_cnt++;
                end
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no in_ready want 1");
        end
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic drain();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t a;
        vec_t b;
        reset     = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        opcode    = '0;
        funct     = '0;
        imm16     = '0;
        rs_data   = '0;
        rt_data   = '0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ctr", ALU_ctr, 0);
        chk("rst_data1", data1, 0);
        chk("rst_cnt", illegal_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // test 1: add
        a = mk(6'h00, 6'h20, 16'h0, 32'd5, 32'd7,
               4'd2, 32'd5, 32'd7, 1'b0);
        send(a, 1'b0);
        @(negedge clk);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_ctr", ALU_ctr, 2);
        @(posedge clk);
        #1;

        // test 2: slti / ori
        send(mk(6'h0A, 6'h00, 16'hFFFF, 32'd3, 32'd0,
                4'd7, 32'hFFFFFFFF, 32'd3, 1'b0), 1'b0);
        send(mk(6'h0D, 6'h00, 16'hFFFF, 32'd3, 32'd0,
                4'd1, 32'd3, 32'h0000FFFF, 1'b0), 1'b0);

        // full decode table, rs=0x10 rt=0x20 imm=0x8001
        tbl.push_back(mk(6'h00, 6'h21, 16'h8001, 32'h10, 32'h20,
                         4'd2, 32'h10, 32'h20, 1'b0));
        tbl.push_back(mk(6'h00, 6'h22, 16'h8001, 32'h10, 32'h20,
                         4'd6, 32'h10, 32'h20, 1'b0));
        tbl.push_back(mk(6'h00, 6'h23, 16'h8001, 32'h10, 32'h20,
                         4'd6, 32'h10, 32'h20, 1'b0));
        tbl.push_back(mk(6'h00, 6'h24, 16'h8001, 32'h10, 32'h20,
                         4'd0, 32'h10, 32'h20, 1'b0));
        tbl.push_back(mk(6'h00, 6'h25, 16'h8001, 32'h10, 32'h20,
                         4'd1, 32'h10, 32'h20, 1'b0));
        tbl.push_back(mk(6'h00, 6'h27, 16'h8001, 32'h10, 32'h20,
                         4'd12, 32'h10, 32'h20, 1'b0));
        tbl.push_back(mk(6'h00, 6'h2A, 16'h8001, 32'h10, 32'h20,
                         4'd7, 32'h20, 32'h10, 1'b0));
        tbl.push_back(mk(6'h00, 6'h1A, 16'h8001, 32'h10, 32'h20,
                         4'd9, 32'h10, 32'h20, 1'b0));
        tbl.push_back(mk(6'h1C, 6'h02, 16'h8001, 32'h10, 32'h20,
                         4'd8, 32'h10, 32'h20, 1'b0));
        tbl.push_back(mk(6'h08, 6'h3F, 16'h8001, 32'h10, 32'h20,
                         4'd2, 32'h10, 32'hFFFF8001, 1'b0));
        tbl.push_back(mk(6'h09, 6'h00, 16'h8001, 32'h10, 32'h20,
                         4'd2, 32'h10, 32'hFFFF8001, 1'b0));
        tbl.push_back(mk(6'h0A, 6'h00, 16'h8001, 32'h10, 32'h20,
                         4'd7, 32'hFFFF8001, 32'h10, 1'b0));
        tbl.push_back(mk(6'h0C, 6'h00, 16'h8001, 32'h10, 32'h20,
                         4'd0, 32'h10, 32'h00008001, 1'b0));
        tbl.push_back(mk(6'h0D, 6'h00, 16'h8001, 32'h10, 32'h20,
                         4'd1, 32'h10, 32'h00008001, 1'b0));
        tbl.push_back(mk(6'h23, 6'h00, 16'h8001, 32'h10, 32'h20,
                         4'd2, 32'h10, 32'hFFFF8001, 1'b0));
        tbl.push_back(mk(6'h2B, 6'h00, 16'h8001, 32'h10, 32'h20,
                         4'd2, 32'h10, 32'hFFFF8001, 1'b0));
        tbl.push_back(mk(6'h04, 6'h00, 16'h8001, 32'h10, 32'h20,
                         4'd6, 32'h10, 32'h20, 1'b0));
        tbl.push_back(mk(6'h05, 6'h00, 16'h8001, 32'h10, 32'h20,
                         4'd3, 32'h10, 32'h20, 1'b0));
        tbl.push_back(mk(6'h00, 6'h00, 16'h8001, 32'h10, 32'h20,
                         4'd15, 32'h0, 32'h0, 1'b1));
        tbl.push_back(mk(6'h1C, 6'h20, 16'h8001, 32'h10, 32'h20,
                         4'd15, 32'h0, 32'h0, 1'b1));
        tbl.push_back(mk(6'h3F, 6'h20, 16'h8001, 32'h10, 32'h20,
                         4'd15, 32'h0, 32'h0, 1'b1));
        foreach (tbl[i]) send(tbl[i], 1'b0);
        drain();
        chk("tbl_cnt", illegal_cnt, exp_cnt);

        // test 3: stall then back-to-back release
        out_ready = 1'b0;
        send(a, 1'b0);
        b = mk(6'h00, 6'h22, 16'h0, 32'd9, 32'd4,
               4'd6, 32'd9, 32'd4, 1'b0);
        opcode   = b.op;
        funct    = b.fn;
        imm16    = b.imm;
        rs_data  = b.rs;
        rt_data  = b.rt;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_in_ready", in_ready, 0);
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_ctr", ALU_ctr, 2);
            chk("t3_hold_d1", data1, 5);
            chk("t3_hold_d2", data2, 7);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_release_ready", in_ready, 1);
        @(posedge clk);
        sb.push_back(b.e);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_no_bubble", out_valid, 1);
        drain();

        // test 4: flush drops the transfer
        send(a, 1'b0);
        send(mk(6'h3F, 6'h00, 16'h0, 32'd1, 32'd2,
                4'd15, 32'd0, 32'd0, 1'b1), 1'b1);
        @(negedge clk);
        chk("t4_ill_flush_valid", out_valid, 0);
        chk("t4_ill_flush_cnt", illegal_cnt, exp_cnt);
        @(posedge clk);
        #1;
        send(a, 1'b1);
        @(negedge clk);
        chk("t4_flush_valid", out_valid, 0);
        @(posedge clk);
        #1;

        // test 5: counter saturation
        for (int i = 0; i < 300; i++)
            send(mk(6'h3F, 6'h00, 16'h1234, 32'd1, 32'd2,
                    4'd15, 32'd0, 32'd0, 1'b1), 1'b0);
        drain();
        chk("t5_cnt_sat", illegal_cnt, 255);
        chk("t5_cnt_model", illegal_cnt, exp_cnt);

        // test 6: async reset mid-stall
        out_ready = 1'b0;
        send(a, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_cnt", illegal_cnt, 0);
        chk("t6_ctr", ALU_ctr, 0);
        chk("t6_data1", data1, 0);
        chk("t6_illegal", illegal, 0);
        sb.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        send(mk(6'h00, 6'h20, 16'h0, 32'd1, 32'd2,
                4'd2, 32'd1, 32'd2, 1'b0), 1'b0);
        @(negedge clk);
        chk("t6_post_valid", out_valid, 1);
        drain();
        chk("t6_post_cnt", illegal_cnt, exp_cnt);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
